// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Holds the scan FSM states, the blank glyph and a counter-width helper.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    ON
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_controller_decoder.sv
// Hex nibble to common-anode 7-segment glyph (active-low, bit0 = a .. bit6 = g).
// Purely combinational; the caller registers the result.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_controller.sv
// Round-robin scan of a multiplexed 7-segment bank with guard interval, PWM,
// leading-zero blanking and once-per-frame input snapshots. Outputs are registered.
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 1024,
  parameter int GUARD_CYCLES = 16,
  parameter int BRIGHT_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      i_en,
  input  logic [4*NUM_DIGITS-1:0]   i_hex,
  input  logic [NUM_DIGITS-1:0]     i_dp,
  input  logic                      i_lzb,
  input  logic [BRIGHT_WIDTH-1:0]   i_brightness,
  output logic [6:0]                o_seg,
  output logic                      o_dp,
  output logic [NUM_DIGITS-1:0]     o_an,
  output logic                      o_frame
);

  localparam int SLOT_W = cnt_width(SLOT_CYCLES);
  localparam int DIG_W  = cnt_width(NUM_DIGITS);

  localparam logic [SLOT_W-1:0]       SLOT_LAST   = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [SLOT_W-1:0]       GUARD_LAST  = SLOT_W'(GUARD_CYCLES - 1);
  localparam logic [SLOT_W-1:0]       GUARD_LEN   = SLOT_W'(GUARD_CYCLES);
  localparam logic [DIG_W-1:0]        DIG_LAST    = DIG_W'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_WIDTH-1:0] BRIGHT_FULL = '1;

  scan_state_t              state, state_nxt;
  logic [SLOT_W-1:0]        slot_cnt, slot_nxt;
  logic [DIG_W-1:0]         digit, digit_nxt;
  logic [4*NUM_DIGITS-1:0]  hex_sh, hex_sh_nxt;
  logic [NUM_DIGITS-1:0]    dp_sh, dp_sh_nxt;
  logic                     lzb_sh, lzb_sh_nxt;
  logic [BRIGHT_WIDTH-1:0]  bright_sh, bright_sh_nxt;

  logic [NUM_DIGITS-1:0]    blank_mask;
  logic                     upper_zero;
  logic [3:0]               nibble;
  logic [6:0]               dec_seg;
  logic [SLOT_W-1:0]        pwm_off;
  logic [BRIGHT_WIDTH-1:0]  pwm_phase;
  logic                     pwm_on;

  logic [NUM_DIGITS-1:0]    an_d;
  logic [6:0]               seg_d;
  logic                     dp_d;
  logic                     frame_d;

  // Next-state logic. Outputs are derived from these next values and registered,
  // so every output lines up with the state it describes.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_nxt     = state;
    slot_nxt      = slot_cnt;
    digit_nxt     = digit;
    hex_sh_nxt    = hex_sh;
    dp_sh_nxt     = dp_sh;
    lzb_sh_nxt    = lzb_sh;
    bright_sh_nxt = bright_sh;

    if (!i_en) begin
      state_nxt = IDLE;
      slot_nxt  = '0;
      digit_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = GUARD;
          slot_nxt  = '0;
          digit_nxt = '0;
        end
        GUARD, ON: begin
          if (slot_cnt == SLOT_LAST) begin
            state_nxt = GUARD;
            slot_nxt  = '0;
            digit_nxt = (digit == DIG_LAST) ? '0 : digit + 1'b1;
          end else begin
            slot_nxt = slot_cnt + 1'b1;
            if (slot_cnt == GUARD_LAST) state_nxt = ON;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Snapshot on entry to the first cycle of the digit-0 guard interval.
    if (state_nxt == GUARD && slot_nxt == '0 && digit_nxt == '0 &&
        (state == IDLE || digit == DIG_LAST)) begin
      hex_sh_nxt    = i_hex;
      dp_sh_nxt     = i_dp;
      lzb_sh_nxt    = i_lzb;
      bright_sh_nxt = i_brightness;
    end
  end

  // Digit k is blanked when every nibble from the top down to k is zero and it has no dp.
  always_comb begin
    blank_mask = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero    = upper_zero && (hex_sh_nxt[4*k +: 4] == 4'h0);
      blank_mask[k] = lzb_sh_nxt && upper_zero && !dp_sh_nxt[k];
    end
  end

  assign nibble = hex_sh_nxt[{digit_nxt, 2'b00} +: 4];

  seg7_decoder u_decoder (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  assign pwm_off   = slot_nxt - GUARD_LEN;
  assign pwm_phase = BRIGHT_WIDTH'(pwm_off);
  assign pwm_on    = (bright_sh_nxt == BRIGHT_FULL) || (pwm_phase < bright_sh_nxt);

  always_comb begin
    an_d    = '1;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    frame_d = (state_nxt == ON) && (slot_nxt == SLOT_LAST) && (digit_nxt == DIG_LAST);
    if (state_nxt != IDLE && !blank_mask[digit_nxt]) begin
      seg_d = dec_seg;
      dp_d  = ~dp_sh_nxt[digit_nxt];
      if (state_nxt == ON && pwm_on) an_d[digit_nxt] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!n_rst) begin
      state     <= IDLE;
      slot_cnt  <= '0;
      digit     <= '0;
      // NOTE: shadow regs are cleared too, so a frame never shows stale power-up data.
      hex_sh    <= '0;
      dp_sh     <= '0;
      lzb_sh    <= 1'b0;
      bright_sh <= '0;
      o_an      <= '1;
      o_seg     <= SEG_BLANK;
      o_dp      <= 1'b1;
      o_frame   <= 1'b0;
    end else begin
      state     <= state_nxt;
      slot_cnt  <= slot_nxt;
      digit     <= digit_nxt;
      hex_sh    <= hex_sh_nxt;
      dp_sh     <= dp_sh_nxt;
      lzb_sh    <= lzb_sh_nxt;
      bright_sh <= bright_sh_nxt;
      o_an      <= an_d;
      o_seg     <= seg_d;
      o_dp      <= dp_d;
      o_frame   <= frame_d;
    end
  end

endmodule
